// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and default width for the bit-serial subtractor
package serial_sub_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/serial_sub8_full_sub.sv
// full_sub: 1-bit full subtractor cell, d = x - y - bi with borrow-out bo
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    always_comb begin
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
    end
endmodule

// File: rtl/serial_sub8.sv
// serial_sub8: bit-serial A - B - BIN, LSB first, one borrow flop, start/done handshake
module serial_sub8
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_part;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;
    logic             w_d;
    logic             w_bo;

    full_sub u_cell (
        .x  (r_sa[0]),
        .y  (r_sb[0]),
        .bi (r_br),
        .d  (w_d),
        .bo (w_bo)
    );

    // Result is committed on the last shift edge so it is valid throughout DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_part  <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_sa    <= a;
                    r_sb    <= b;
                    r_br    <= bin;
                    r_cnt   <= '0;
                    busy    <= 1'b1;
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_sa   <= r_sa >> 1;
                    r_sb   <= r_sb >> 1;
                    r_br   <= w_bo;
                    r_part <= {w_d, r_part[WIDTH-1:1]};
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        diff    <= {w_d, r_part[WIDTH-1:1]};
                        bout    <= w_bo;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub8.sv
// tb_serial_sub8: directed and randomized checks of serial_sub8 against an arithmetic model
module tb_serial_sub8;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_done = -1;
    logic prev_done = 1'b0;

    serial_sub8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (done) begin
            checks++;
            if (busy) begin
                errors++;
                $display("FAIL busy_done_overlap at cycle %0d: busy=%b done=%b, required busy=0", cyc, busy, done);
            end
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL done_double at cycle %0d: done high two cycles, required single pulse", cyc);
            end
            if (last_done >= 0) begin
                checks++;
                if (cyc - last_done < W + 2) begin
                    errors++;
                    $display("FAIL done_spacing at cycle %0d: got %0d cycles, required >= %0d", cyc, cyc - last_done, W + 2);
                end
            end
            last_done = cyc;
        end
        if (!rst_n) last_done = -1;
        prev_done = done;
    end

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    endfunction

    // Launches one op and returns the cycle index at which done was seen (-1 on timeout).
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; bin = 1'($urandom);
        lat = 1;
        busy_cnt = int'(busy);
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
            busy_cnt += int'(busy);
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, diff, bout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b diff=%h bout=%b, required all 0", busy, done, diff, bout);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [6] = '{8'h01, 8'h00, 8'hFF, 8'h02, 8'h25, 8'h00};
        logic [W-1:0] vb [6] = '{8'h01, 8'h01, 8'h00, 8'hFB, 8'h22, 8'hFF};
        logic         vc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [W:0]   ve [6] = '{9'h000, 9'h1FF, 9'h0FE, 9'h106, 9'h002, 9'h100};
        int lat, bc;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], vc[i], lat, bc);
            checks++;
            if (lat != W + 1) begin
                errors++;
                $display("FAIL dir_latency[%0d]: got %0d, required %0d", i, lat, W + 1);
            end
            checks++;
            if (bc != W) begin
                errors++;
                $display("FAIL dir_busy_cycles[%0d]: got %0d, required %0d", i, bc, W);
            end
            checks++;
            if ({bout, diff} !== ve[i]) begin
                errors++;
                $display("FAIL dir_result[%0d]: got bout=%b diff=%h, required bout=%b diff=%h", i, bout, diff, ve[i][W], ve[i][W-1:0]);
            end
        end
    endtask

    task automatic test_stray_start();
        int lat = 1;
        int dones = 0;
        @(negedge clk);
        a = 8'h91; b = 8'h90; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 30) begin
            start = (lat == 3 || lat == 8);
            a = 8'h0F; b = 8'hF0; bin = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b1;
        checks++;
        if (!done || {bout, diff} !== 9'h000) begin
            errors++;
            $display("FAIL stray_result: done=%b bout=%b diff=%h, required done=1 bout=0 diff=00", done, bout, diff);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (15) begin
            dones += int'(done);
            @(negedge clk);
        end
        checks++;
        if (dones != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_not_queued: extra dones=%0d busy=%b, required 0 0", dones, busy);
        end
        checks++;
        if ({bout, diff} !== 9'h000) begin
            errors++;
            $display("FAIL stray_hold: bout=%b diff=%h, required bout=0 diff=00", bout, diff);
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat, bc;
        int dones = 0;
        do_op(8'h55, 8'h11, 1'b0, lat, bc);
        checks++;
        if ({bout, diff} !== 9'h044) begin
            errors++;
            $display("FAIL pre_reset_result: bout=%b diff=%h, required bout=0 diff=44", bout, diff);
        end
        @(negedge clk);
        a = 8'h18; b = 8'h30; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, diff, bout} !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b diff=%h bout=%b, required all 0", busy, done, diff, bout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) begin
            @(negedge clk);
            dones += int'(done) + int'(busy);
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_abort: busy/done seen %0d times after reset, required 0", dones);
        end
        do_op(8'h30, 8'h18, 1'b0, lat, bc);
        checks++;
        if (lat != W + 1 || {bout, diff} !== 9'h018) begin
            errors++;
            $display("FAIL post_reset_op: lat=%0d bout=%b diff=%h, required lat=%0d bout=0 diff=18", lat, bout, diff, W + 1);
        end
    endtask

    task automatic test_random();
        int lat, bc;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   exp_v;
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if (i % 50 == 0) ra = (i % 100 == 0) ? '0 : '1;
            exp_v = model(ra, rb, rc);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            do_op(ra, rb, rc, lat, bc);
            checks++;
            if (lat != W + 1 || {bout, diff} !== exp_v) begin
                errors++;
                $display("FAIL rand[%0d] %h-%h-%b: lat=%0d bout=%b diff=%h, required lat=%0d bout=%b diff=%h",
                         i, ra, rb, rc, lat, bout, diff, W + 1, exp_v[W], exp_v[W-1:0]);
            end
        end
    endtask

    initial begin
        #3;
        rst_n = 1'b0;
        test_reset();
        test_directed();
        test_stray_start();
        test_reset_mid_shift();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_sub8.md
Name: serial_sub8

Overview:
Bit-serial subtractor computing DIFF = A - B - BIN over WIDTH clock cycles, LSB first, with one borrow flop. It is the subtract-side counterpart of the team's combinational 8-bit ripple adder. It sits beside that adder on the data-flow path and accepts operands through a start/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden)

Ports:
clk     input   1      system clock; rising edge active
rst_n   input   1      asynchronous active-low reset
start   input   1      request; sampled only in IDLE
a       input   WIDTH  minuend; captured on accepted start
b       input   WIDTH  subtrahend; captured on accepted start
bin     input   1      borrow-in; captured on accepted start
busy    output  1      high while in SHIFT
done    output  1      one-cycle pulse; result valid
diff    output  WIDTH  registered difference; held until the next result
bout    output  1      registered borrow-out; 1 iff a < b + bin (unsigned)

Behaviour:
- Reset (rst_n=0, async): state=IDLE, busy=0, done=0, diff=0, bout=0. Operand shift registers, borrow flop and counter all clear.
- States: IDLE, SHIFT, DONE (2-bit encoding from package).
- IDLE:
  - start=1 -> latch a, b, bin into sa, sb, br; cnt=0; go to SHIFT.
  - start=0 -> stay in IDLE.
- SHIFT: on each clock:
  - d = sa[0]^sb[0]^br
  - br <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br)
  - sa and sb shift right by 1
  - d shifts into the MSB of the partial-result register
  - cnt increments
  - Transition: after WIDTH shift cycles (cnt==WIDTH-1 on the current edge) go to DONE.
- DONE, for one cycle:
  - diff <= partial result; bout <= br; done=1.
  - Next state is IDLE unconditionally.
- Latency: start sampled at edge N -> busy high for cycles N+1..N+WIDTH -> done high for cycle N+WIDTH+1, with diff and bout valid in that same cycle (WIDTH=8 gives 9 cycles). Back-to-back throughput is one operation per WIDTH+2 cycles.
- start while in SHIFT or DONE is ignored and not queued. Operand inputs are don't-care outside the accept edge.
- diff and bout change only in DONE and otherwise hold their last value, including across ignored starts.
- Arithmetic is unsigned modulo 2^WIDTH. Wrap-around is reported only via bout; there is no overflow flag.
- rst_n low mid-SHIFT: computation aborts immediately. Outputs return to reset values; no done pulse is generated.
- rst_n release: synchronous release is the SoC's job. The block requires a clean deassert before the first start.
- busy and done are never high together. done is never high for 2 consecutive cycles.

Decomposition:
- Package serial_sub_pkg:
  - state typedef/localparams ST_IDLE=0, ST_SHIFT=1, ST_DONE=2
  - default WIDTH constant
- Sub-module full_sub: 1-bit combinational cell (x, y, bi -> d, bo) instantiated once in the SHIFT datapath. It is the mirror of the adder's full-adder cell.

Test Plan:
- Reset with outputs checked, then a=0x01, b=0x01, bin=0 -> done at start+9, diff=0x00, bout=0. busy is high exactly 8 cycles.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0xFF, b=0x00, bin=1 -> diff=0xFE, bout=0.
- a=0x02, b=0xFB, bin=1 -> diff=0x06, bout=1. a=0x25, b=0x22, bin=1 -> diff=0x02, bout=0. a=0x00, b=0xFF, bin=1 -> diff=0x00, bout=1.
- Pulse start again at cycles 3 and 8 of a SHIFT (a=0x91, b=0x90, bin=1), and again during DONE. Result is diff=0x00, bout=0, with exactly one done pulse. Stray starts do not alter the result, and the next op needs a fresh start in IDLE.
- Drop rst_n for 1 cycle mid-SHIFT (cycle 4) of a=0x18, b=0x30. Outputs go to 0 asynchronously; no done pulse; state is IDLE. A following op a=0x30, b=0x18, bin=0 -> diff=0x18, bout=0.
- Random sweep of 1000 ops with a scoreboard {bout,diff} == ({1'b0,a} - {1'b0,b} - bin) mod 2^9, checking done spacing >= WIDTH+2 cycles.
